// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the core's instruction-fetch path
//   and its data load/store path. One access is in flight at a time. Data
//   accesses win ties unless fetch has already waited MAX_DATA_RUN data
//   grants. Each access runs IDLE -> FETCH/DATA -> DONE -> IDLE.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   if_req/if_addr      fetch request (held until if_valid) and PC
//   if_rdata/if_valid   fetched instruction and one-cycle completion pulse
//   dm_req/dm_we/dm_size/dm_addr/dm_wdata
//                       data request (held until dm_valid) and its attributes
//   dm_rdata/dm_valid   load data and one-cycle completion pulse
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata
//                       registered memory request, stable until mem_ack
//   mem_rdata/mem_ack   memory read data, valid with the one-cycle ack
//   stall               core must hold while any request is unserved
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic [1:0]    dm_we,
  input  logic [2:0]    dm_size,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_req,
  output logic [1:0]    mem_we,
  output logic [2:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall
);

  localparam int CW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DATA_RUN);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] run_cnt;
  logic          gnt_data;   // side that owns the access in flight
  logic          grant_fetch, grant_data;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; fetch only overtakes a pending data request once the
  // data side has used up its run budget.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dm_req && !(if_req && run_cnt == RUN_MAX)) state_nxt = DATA;
        else if (if_req)                               state_nxt = FETCH;
      end
      FETCH, DATA: if (mem_ack) state_nxt = DONE;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  assign grant_fetch = (state == IDLE) && (state_nxt == FETCH);
  assign grant_data  = (state == IDLE) && (state_nxt == DATA);

  // Completion pulses come straight from DONE
  always_comb begin
    if_valid = 1'b0;
    dm_valid = 1'b0;
    if (state == DONE) begin
      if_valid = !gnt_data;
      dm_valid = gnt_data;
    end
  end

  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

  // Grant capture, run counter and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt   <= '0;
      gnt_data  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 2'b00;
      mem_size  <= 3'b000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // Request is high exactly while the FSM waits in FETCH or DATA
      mem_req <= (state_nxt == FETCH) || (state_nxt == DATA);

      if (grant_data) begin
        gnt_data  <= 1'b1;
        mem_we    <= dm_we;
        mem_size  <= dm_size;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        if (!if_req)                 run_cnt <= '0;
        else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
      end

      // Fetches are always word loads; store data is left as it was
      if (grant_fetch) begin
        gnt_data <= 1'b0;
        mem_we   <= 2'b00;
        mem_size <= 3'b010;
        mem_addr <= if_addr;
        run_cnt  <= '0;
      end

      if (mem_ack) begin
        if (state == FETCH)                         if_rdata <= mem_rdata;
        else if (state == DATA && mem_we == 2'b00)  dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomized requesters and a random-latency memory drive mem_port_arbiter.
//   A transaction-level reference model predicts each grant's winner and
//   attributes, the completion pulses, captured read data and stall.
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MAX_RUN = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, dm_req, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [1:0]    dm_we;
  logic [2:0]    dm_size;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic          if_valid, dm_valid, mem_req, stall;
  logic [1:0]    mem_we;
  logic [2:0]    mem_size;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (one transaction at a time)
  int            run_len;       // consecutive data grants while fetch waited
  bit            busy;          // access granted, ack not yet seen
  int            cooldown;      // edges before arbitration resumes
  bit            g_data;
  logic [1:0]    e_we;
  logic [2:0]    e_size;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_if_rdata, e_dm_rdata;
  bit            e_ifv, e_dmv;

  // Stimulus state
  int keep_pct;
  bit seen;
  int wait_cnt;
  int n_fetch = 0, n_data = 0;

  task automatic model_reset();
    run_len = 0; busy = 0; cooldown = 0; g_data = 0;
    e_we = '0; e_size = '0; e_addr = '0; e_wdata = '0;
    e_if_rdata = '0; e_dm_rdata = '0; e_ifv = 0; e_dmv = 0;
    seen = 0; wait_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"},  mem_req,   0);
    chk({tag, "_mem_we"},   mem_we,    0);
    chk({tag, "_mem_size"}, mem_size,  0);
    chk({tag, "_mem_addr"}, mem_addr,  0);
    chk({tag, "_mem_wdat"}, mem_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata,  0);
    chk({tag, "_dm_rdata"}, dm_rdata,  0);
    chk({tag, "_if_valid"}, if_valid,  0);
    chk({tag, "_dm_valid"}, dm_valid,  0);
    chk({tag, "_stall"},    stall,     if_req | dm_req);
  endtask

  task automatic new_fetch();
    if_req  = 1'b1;
    if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
  endtask

  task automatic new_data();
    dm_req   = 1'b1;
    dm_we    = 2'($urandom_range(0, 3));
    dm_size  = 3'($urandom_range(0, 7));
    dm_addr  = $urandom;
    dm_wdata = $urandom;
  endtask

  // One clock: advance the model over the edge, compare, then drive the next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    e_ifv = 0;
    e_dmv = 0;
    if (cooldown > 0) cooldown--;
    if (busy && mem_ack) begin
      busy     = 0;
      cooldown = 2;
      if (g_data) begin
        e_dmv = 1;
        if (e_we == 2'b00) e_dm_rdata = mem_rdata;
      end else begin
        e_ifv      = 1;
        e_if_rdata = mem_rdata;
      end
    end else if (!busy && cooldown == 0 && (if_req || dm_req)) begin
      g_data = dm_req && !(if_req && run_len == MAX_RUN);
      busy   = 1;
      if (g_data) begin
        n_data++;
        run_len = if_req ? ((run_len < MAX_RUN) ? run_len + 1 : MAX_RUN) : 0;
        e_we = dm_we; e_size = dm_size; e_addr = dm_addr; e_wdata = dm_wdata;
      end else begin
        n_fetch++;
        run_len = 0;
        e_we = 2'b00; e_size = 3'b010; e_addr = if_addr;
      end
    end

    chk("mem_req",  mem_req,  busy);
    chk("if_valid", if_valid, e_ifv);
    chk("dm_valid", dm_valid, e_dmv);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("dm_rdata", dm_rdata, e_dm_rdata);
    chk("stall",    stall,    (if_req & ~e_ifv) | (dm_req & ~e_dmv));
    if (busy) begin
      chk("mem_we",    mem_we,    e_we);
      chk("mem_size",  mem_size,  e_size);
      chk("mem_addr",  mem_addr,  e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end

    // Memory: random wait of 0..5 cycles, occasional spurious ack when idle
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!seen) begin
        seen     = 1;
        wait_cnt = $urandom_range(0, 5);
      end
      if (wait_cnt == 0) begin
        mem_ack = 1'b1;
        seen    = 0;
      end else wait_cnt--;
    end else begin
      seen = 0;
      if ($urandom_range(0, 7) == 0) mem_ack = 1'b1;
    end

    // Requesters: on completion either issue a new request or drop;
    // attributes wander while waiting since only the grant edge matters
    if (if_req) begin
      if (if_valid) begin
        if ($urandom_range(0, 99) < keep_pct) new_fetch();
        else if_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) if_addr = $urandom;
    end else if ($urandom_range(0, 2) == 0) new_fetch();

    if (dm_req) begin
      if (dm_valid) begin
        if ($urandom_range(0, 99) < keep_pct) new_data();
        else dm_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        dm_addr  = $urandom;
        dm_wdata = $urandom;
        dm_we    = 2'($urandom_range(0, 3));
      end
    end else if ($urandom_range(0, 2) == 0) new_data();
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b1; if_addr = '0;
    dm_req = 1'b0; dm_we = '0; dm_size = '0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = 32'h0050_0093;
    model_reset();
    keep_pct = 60;

    #2;
    chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst1");
    #2 reset = 1'b1;

    repeat (400) step();

    keep_pct = 100;
    repeat (200) step();

    // Reset in the middle of a data access
    begin
      int guard = 0;
      while (!(busy && g_data) && guard < 200) begin
        step();
        guard++;
      end
      chk("mid_rst_reach", guard < 200, 1);
    end
    chk("mid_rst_req_before", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_rst_hold");
    #2 reset = 1'b1;
    model_reset();
    mem_ack = 1'b1;    // late ack after release must be ignored
    step();
    chk("late_ack_no_valid", if_valid | dm_valid, 0);

    keep_pct = 50;
    repeat (400) step();

    chk("saw_fetch_grants", n_fetch > 20, 1);
    chk("saw_data_grants",  n_data > 20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported memory between the CPU core's instruction-fetch path and its data load/store path. It serialises the two requesters onto the memory port with a registered request/acknowledge handshake and generates the core's stall. Data accesses have priority, and a bounded-run counter guarantees fetch forward progress. It sits between the core's `PC`/`instr` and `ALU_result`/`data_out`/`data_in`/`MemWrite`/`SizeLoad` signals and the memory.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_DATA_RUN`, 4, maximum consecutive data grants while a fetch is pending (≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `if_req`  in  1  fetch request, held until `if_valid`
- `if_addr`  in  AW  fetch address (PC)
- `if_rdata`  out  DW  fetched instruction
- `if_valid`  out  1  one-cycle fetch completion pulse
- `dm_req`  in  1  data request, held until `dm_valid`
- `dm_we`  in  2  store size: 00 none (load), 01 byte, 10 half, 11 word
- `dm_size`  in  3  load size/sign code, passed through
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  store data
- `dm_rdata`  out  DW  load data
- `dm_valid`  out  1  one-cycle data completion pulse
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`, `mem_size`, `mem_addr`, `mem_wdata`  out  2/3/AW/DW  registered access attributes
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  one-cycle completion from memory
- `stall`  out  1  core must hold PC/state

## Operation
- FSM states: IDLE, FETCH, DATA, DONE.
- IDLE:
  - Only `if_req` → FETCH.
  - Only `dm_req` → DATA.
  - Both high → DATA, unless `run_cnt == MAX_DATA_RUN`, then FETCH.
  - Neither → stay in IDLE.
- On grant:
  - Register the winner's attributes into `mem_*`.
  - Fetch grants force `mem_we=00` and `mem_size=3'b010`, with `mem_wdata` held.
  - Raise `mem_req`.
- FETCH/DATA:
  - Hold `mem_req` and attributes stable until `mem_ack`.
  - On `mem_ack` → DONE. Capture `mem_rdata` into `if_rdata` (FETCH), or into `dm_rdata` (DATA with `mem_we==00` only). For stores, `dm_rdata` holds.
- DONE:
  - `mem_req=0`.
  - Pulse the granted side's `*_valid` for one cycle.
  - Ignore all requests.
  - → IDLE next cycle.
- `run_cnt`, width clog2(MAX_DATA_RUN+1):
  - Data grant with `if_req` high: increments, saturating.
  - Data grant with `if_req` low: cleared.
  - Fetch grant: cleared.
- `mem_ack` outside FETCH/DATA is ignored.
- `stall = (if_req & ~if_valid) | (dm_req & ~dm_valid)`, combinational.

## Timing
- Reset (async, immediate):
  - State = IDLE; `run_cnt=0`.
  - `mem_req=0`, `mem_we=0`, `mem_size=0`, `mem_addr=0`, `mem_wdata=0`.
  - `if_rdata=0`, `dm_rdata=0`, `if_valid=0`, `dm_valid=0`.
  - `stall` follows its equation.
- Reset mid-transaction drops `mem_req` at once. The outstanding access is abandoned, and a late `mem_ack` after reset release is ignored.
- Request sampled in IDLE at edge N → `mem_req=1` in cycle N+1.
- `mem_ack` in cycle M (M ≥ N+1) → `*_valid` and rdata valid in cycle M+1.
- Requester must drop `req` by cycle M+2. IDLE re-evaluates at M+2.
- Minimum access: 3 cycles with zero-wait memory (`mem_ack` in the first request cycle). Back-to-back grants are spaced 3 cycles apart.
- Requester signals are sampled only at the grant edge. Later changes are ignored until the next grant.

## Test plan
- Reset with `if_req=1`, `if_addr=0x0` held; `mem_ack` returned 1 cycle after each `mem_req` with `mem_rdata=0x00500093` → `mem_req` rises 1 cycle after release, `if_valid` pulses with `if_rdata=0x00500093`, `stall` is low only in the valid cycle.
- Simultaneous `if_req`/`dm_req` (load, `dm_addr=0x100`, memory returns `0xDEADBEEF`) → data granted first with `mem_we=00`, `dm_rdata=0xDEADBEEF`, then fetch is granted.
- `dm_req` store (`dm_we=11`, `dm_wdata=0x12345678`, `dm_addr=0x40`) → `mem_we=11`, `mem_wdata=0x12345678`, `dm_valid` pulses, `dm_rdata` unchanged.
- `dm_req` held continuously with `if_req` pending, `MAX_DATA_RUN=4` → exactly 4 data grants, then 1 fetch grant, then data again.
- Memory wait of 5 cycles → `mem_req` and attributes stable all 5 cycles, single `*_valid` pulse, spurious `mem_ack` in IDLE ignored.
- Assert `reset=0` while in DATA with `mem_req=1` → `mem_req=0` the same cycle, all outputs at reset values, a late `mem_ack` produces no valid pulse.
